// File: rtl/pic_pkg.sv
// Shared PIC types.
//   eoi_cmd_t   : OCW2 EOI command encoding (bit0 = specific, bit1 = rotate)
//   isr_state_t : INTA sequence state for the ISR controller
package pic_pkg;

   typedef enum logic [1:0] {
      EOI_NS       = 2'b00,
      EOI_SPEC     = 2'b01,
      EOI_ROT_NS   = 2'b10,
      EOI_ROT_SPEC = 2'b11
   } eoi_cmd_t;

   typedef enum logic {
      IDLE     = 1'b0,
      ACK_PEND = 1'b1
   } isr_state_t;

   function automatic logic eoi_is_specific(input eoi_cmd_t cmd);
      return (cmd == EOI_SPEC) || (cmd == EOI_ROT_SPEC);
   endfunction

   function automatic logic eoi_is_rotate(input eoi_cmd_t cmd);
      return (cmd == EOI_ROT_NS) || (cmd == EOI_ROT_SPEC);
   endfunction

endpackage

// File: rtl/circ_prio_find.sv
// Circular priority finder (combinational).
//   req     : request/in-service bit vector
//   hi_prio : level with the highest priority; priority falls with hi_prio+1, +2, ... mod NUM_IRQ
//   found   : at least one bit of req is set
//   idx     : highest-priority set level (0 when found=0)
module circ_prio_find
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int IDX_W   = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req,
   input  logic [IDX_W-1:0]   hi_prio,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // Walk levels in priority order; the index sum wraps naturally in IDX_W bits.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_IRQ; k++) begin
         cand = hi_prio + IDX_W'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/isr_ctrl_param.sv
// In-service register controller for the PIC.
// Tracks in-service levels, produces the vector over the two-pulse INTA
// sequence, and handles AEOI, non-specific/specific EOI and rotation.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ack1/ack1_valid/ack1_idx : first INTA pulse and resolver winner
//   ack2                : second INTA pulse
//   icw_base            : vector base (low IDX_W bits ignored)
//   aeoi_en, rot_aeoi   : automatic EOI, rotate on automatic EOI
//   eoi_req/eoi_cmd/eoi_level : OCW2 EOI command
//   isr_value, hi_prio  : ISR contents, highest-priority level
//   vector/vector_valid/spurious : vector output and its pulses
//   eoi_done/cleared_idx: clear pulse and the level cleared
module isr_ctrl_param
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int IDX_W   = $clog2(NUM_IRQ),
   parameter int VEC_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ack1,
   input  logic               ack1_valid,
   input  logic [IDX_W-1:0]   ack1_idx,
   input  logic               ack2,
   input  logic [VEC_W-1:0]   icw_base,
   input  logic               aeoi_en,
   input  logic               eoi_req,
   input  logic [1:0]         eoi_cmd,
   input  logic [IDX_W-1:0]   eoi_level,
   input  logic               rot_aeoi,
   output logic [NUM_IRQ-1:0] isr_value,
   output logic [IDX_W-1:0]   hi_prio,
   output logic [VEC_W-1:0]   vector,
   output logic               vector_valid,
   output logic               spurious,
   output logic               eoi_done,
   output logic [IDX_W-1:0]   cleared_idx
);

   isr_state_t state_q, state_d;
   logic       ack2_fire;

   logic [IDX_W-1:0]   cur_idx;
   logic               spur_q;

   eoi_cmd_t           cmd;
   logic               ns_found;
   logic [IDX_W-1:0]   ns_idx;
   logic               aeoi_fire, eoi_fire, clr_en, rot_en;
   logic [IDX_W-1:0]   eoi_tgt, clr_idx;
   logic [NUM_IRQ-1:0] clr_mask, set_mask, isr_d;
   logic [VEC_W-1:0]   vec_d;

   circ_prio_find #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_find (
      .req     (isr_value),
      .hi_prio (hi_prio),
      .found   (ns_found),
      .idx     (ns_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ack1 dominates ack2 in the same cycle; ack2 outside ACK_PEND is ignored.
   always_comb begin
      state_d   = state_q;
      ack2_fire = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ack1) state_d = ACK_PEND;
         end
         ACK_PEND: begin
            if (ack1) begin
               state_d = ACK_PEND;
            end else if (ack2) begin
               state_d   = IDLE;
               ack2_fire = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Clear and set are both derived from the pre-edge ISR; set is applied last
   // so a bit set and cleared together ends at 1. AEOI pre-empts any EOI.
   always_comb begin
      cmd       = eoi_cmd_t'(eoi_cmd);
      aeoi_fire = ack2_fire & aeoi_en & ~spur_q;
      eoi_tgt   = eoi_is_specific(cmd) ? eoi_level : ns_idx;
      eoi_fire  = eoi_req & ~aeoi_fire &
                  (eoi_is_specific(cmd) ? isr_value[eoi_level] : ns_found);
      clr_en    = aeoi_fire | eoi_fire;
      clr_idx   = aeoi_fire ? cur_idx : eoi_tgt;
      rot_en    = aeoi_fire ? rot_aeoi : eoi_is_rotate(cmd);
      clr_mask  = '0;
      set_mask  = '0;
      if (clr_en)             clr_mask[clr_idx]  = 1'b1;
      if (ack1 && ack1_valid) set_mask[ack1_idx] = 1'b1;
      isr_d     = (isr_value & ~clr_mask) | set_mask;
      vec_d     = (icw_base & ~VEC_W'(NUM_IRQ - 1)) | VEC_W'(cur_idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isr_value    <= '0;
         hi_prio      <= '0;
         vector       <= '0;
         vector_valid <= 1'b0;
         spurious     <= 1'b0;
         eoi_done     <= 1'b0;
         cleared_idx  <= '0;
         cur_idx      <= '0;
         spur_q       <= 1'b0;
      end else begin
         isr_value    <= isr_d;
         vector_valid <= ack2_fire;
         spurious     <= ack2_fire & spur_q;
         eoi_done     <= clr_en;
         if (ack2_fire) vector <= vec_d;
         if (clr_en) begin
            cleared_idx <= clr_idx;
            if (rot_en) hi_prio <= clr_idx + 1'b1;
         end
         // A spurious acknowledge reports the lowest-priority level.
         if (ack1) begin
            cur_idx <= ack1_valid ? ack1_idx : hi_prio - 1'b1;
            spur_q  <= ~ack1_valid;
         end
      end
   end

endmodule

// File: doc/isr_ctrl_param.md
Name: isr_ctrl_param

Overview:
- Clocked, parametrised in-service register (ISR) controller for the PIC.
- Tracks which of NUM_IRQ levels are in service and generates the interrupt vector across the two-pulse INTA sequence.
- Supports automatic EOI, non-specific EOI, specific EOI and rotating priority.
- Sits between the priority resolver (which supplies the winning level) and the data bus buffer (which consumes the vector and ISR readback).

Parameters:
- NUM_IRQ, 8, number of interrupt levels; power of two, 2..32.
- IDX_W, $clog2(NUM_IRQ), width of a level index.
- VEC_W, 8, vector width; IDX_W <= VEC_W required.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ack1  in  1  first INTA pulse, one cycle
- ack1_valid  in  1  resolver has a real winner during ack1
- ack1_idx  in  IDX_W  winning level from resolver
- ack2  in  1  second INTA pulse, one cycle
- icw_base  in  VEC_W  vector base from ICW2; low IDX_W bits ignored
- aeoi_en  in  1  automatic EOI enabled (ICW4)
- eoi_req  in  1  OCW2 EOI command strobe, one cycle
- eoi_cmd  in  2  00 non-specific, 01 specific, 10 rotate non-specific, 11 rotate specific
- eoi_level  in  IDX_W  level for specific commands
- rot_aeoi  in  1  rotate priority on each AEOI clear
- isr_value  out  NUM_IRQ  current ISR contents, to resolver and readback
- hi_prio  out  IDX_W  current highest-priority level
- vector  out  VEC_W  vector to the data buffer
- vector_valid  out  1  one-cycle pulse, vector is valid
- spurious  out  1  one-cycle pulse, spurious acknowledge
- eoi_done  out  1  one-cycle pulse, a bit was cleared
- cleared_idx  out  IDX_W  level cleared by the last EOI or AEOI

Behaviour:
- Reset (async, rst_n=0): isr_value=0, hi_prio=0, vector=0, cleared_idx=0, all pulses 0, FSM=IDLE.
- FSM states:
  - IDLE -> ACK_PEND on ack1.
  - ACK_PEND -> IDLE on ack2.
  - ack1 while in ACK_PEND: restart the sequence (latch new data), stay in ACK_PEND.
  - ack2 while in IDLE: ignored, no pulse.
- Level priority is circular: hi_prio is highest, then hi_prio+1, and so on mod NUM_IRQ.
- ack1 with ack1_valid=1:
  - Next edge: set isr_value[ack1_idx] and latch cur_idx=ack1_idx.
- ack1 with ack1_valid=0:
  - No ISR change; latch cur_idx=(hi_prio-1) mod NUM_IRQ (lowest priority); set the spurious flag.
- ack2 in ACK_PEND:
  - Next edge: vector={icw_base[VEC_W-1:IDX_W], cur_idx}, vector_valid=1 for one cycle.
  - spurious=1 for that same cycle if the flag is set.
  - vector holds its value until the next ack2.
- AEOI: if aeoi_en=1 and not spurious, the same edge as vector_valid also:
  - clears isr_value[cur_idx];
  - cleared_idx=cur_idx, eoi_done=1;
  - if rot_aeoi=1, hi_prio=(cur_idx+1) mod NUM_IRQ.
- eoi_req, non-specific (00/10): clear the highest-priority set bit of isr_value, using a circular scan from hi_prio.
- eoi_req, specific (01/11): clear isr_value[eoi_level].
- Rotate variants (10/11): hi_prio=(cleared level+1) mod NUM_IRQ.
- EOI timing: takes effect on the next edge; eoi_done=1 for one cycle and cleared_idx updated.
- EOI on empty or unset target: no-op.
  - Non-specific with isr_value=0, or specific with the bit already 0.
  - eoi_done stays 0, hi_prio and cleared_idx unchanged.
- Simultaneous events in one cycle:
  - Set and clear are computed from the pre-edge isr_value; the set is applied after the clear.
  - Same bit set and cleared: bit ends at 1.
  - AEOI and eoi_req both fire: AEOI has priority for cleared_idx/hi_prio and eoi_req is dropped; an eoi_done from the dropped request must not occur.
  - ack1 and ack2 together: ack1 wins, ack2 is ignored.
- Arithmetic: all index math is mod NUM_IRQ, natural wrap in IDX_W bits. No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package pic_pkg holds:
  - eoi_cmd_t enum (EOI_NS, EOI_SPEC, EOI_ROT_NS, EOI_ROT_SPEC);
  - isr_state_t enum (IDLE, ACK_PEND).
- One sub-module, circ_prio_find: combinational, parametrised on NUM_IRQ.
  - Inputs: a bit vector and hi_prio.
  - Outputs: found flag and index of the highest-priority set bit.
  - Used for non-specific EOI; reusable by the priority resolver.

Test Plan:
- AEOI off, icw_base=8'h40: ack1 (valid, idx=3), ack2 -> isr_value=8'h08, vector=8'h43 with one-cycle vector_valid, no eoi_done.
- aeoi_en=1, rot_aeoi=1, icw_base=8'h20, ack idx=5 -> vector=8'h25; isr bit 5 cleared on the same edge; eoi_done=1, cleared_idx=5, hi_prio=6.
- isr_value=8'h09 (bits 0 and 3), hi_prio=2, non-specific EOI -> bit 3 cleared (highest after circular scan from 2), isr_value=8'h01; then rotate specific EOI level 0 -> isr_value=0, hi_prio=1.
- ack1 with ack1_valid=0, hi_prio=0, icw_base=8'h08 -> after ack2: vector=8'h0F, spurious=1, isr_value unchanged, no eoi_done.
- Same cycle: ack1 (idx 2) and specific EOI level 2 with bit 2 already set -> isr bit 2 remains 1. Separately, specific EOI on a cleared bit -> no eoi_done.
- Assert rst_n=0 asynchronously while in ACK_PEND with isr_value=8'hFF -> outputs zero immediately; a following ack2 produces no vector_valid. Repeat the AEOI scenario with NUM_IRQ=16 (vector={icw_base[7:4], idx}).
